// File: rtl/brimstone_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package brimstone_pkg;

  localparam int unsigned DATA_WIDTH_DEF      = 32;
  localparam int unsigned DATA_ADDR_WIDTH_DEF = 32;
  localparam int unsigned BURST_MAX_DEF       = 4;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester, enable and memory-side signals of the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int unsigned DATA_WIDTH_P      = brimstone_pkg::DATA_WIDTH_DEF,
  parameter int unsigned DATA_ADDR_WIDTH_P = brimstone_pkg::DATA_ADDR_WIDTH_DEF
);
  logic                         i_enable;
  logic                         i_a_req;
  logic                         i_b_req;
  logic                         i_a_wr_en;
  logic                         i_b_wr_en;
  logic                         i_a_lock;
  logic                         i_b_lock;
  logic [DATA_ADDR_WIDTH_P-1:0] i_a_addr;
  logic [DATA_ADDR_WIDTH_P-1:0] i_b_addr;
  logic [DATA_WIDTH_P-1:0]      i_a_wr_data;
  logic [DATA_WIDTH_P-1:0]      i_b_wr_data;
  logic                         o_a_gnt;
  logic                         o_b_gnt;
  logic                         o_a_rd_valid;
  logic                         o_b_rd_valid;
  logic [DATA_WIDTH_P-1:0]      o_a_rd_data;
  logic [DATA_WIDTH_P-1:0]      o_b_rd_data;
  logic                         o_mem_wr_en;
  logic [DATA_ADDR_WIDTH_P-1:0] o_mem_addr;
  logic [DATA_WIDTH_P-1:0]      o_mem_wr_data;
  logic [DATA_WIDTH_P-1:0]      i_mem_rd_data;

  modport slave (
    input  i_enable, i_a_req, i_b_req, i_a_wr_en, i_b_wr_en, i_a_lock, i_b_lock,
    input  i_a_addr, i_b_addr, i_a_wr_data, i_b_wr_data, i_mem_rd_data,
    output o_a_gnt, o_b_gnt, o_a_rd_valid, o_b_rd_valid, o_a_rd_data, o_b_rd_data,
    output o_mem_wr_en, o_mem_addr, o_mem_wr_data
  );

  modport master (
    output i_enable, i_a_req, i_b_req, i_a_wr_en, i_b_wr_en, i_a_lock, i_b_lock,
    output i_a_addr, i_b_addr, i_a_wr_data, i_b_wr_data, i_mem_rd_data,
    input  o_a_gnt, o_b_gnt, o_a_rd_valid, o_b_rd_valid, o_a_rd_data, o_b_rd_data,
    input  o_mem_wr_en, o_mem_addr, o_mem_wr_data
  );
endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way chooser: sole requester wins, ties go to the lock owner
// if a lock is active, otherwise to the port not granted last.
module rr_pick2
  import brimstone_pkg::*;
(
  input  logic    req_a,
  input  logic    req_b,
  input  req_id_t last,
  input  logic    lock_active,
  input  req_id_t lock_owner,
  output logic    gnt_a,
  output logic    gnt_b
);
  req_id_t tie_winner;

  always_comb begin
    tie_winner = lock_active ? lock_owner : ((last == REQ_B) ? REQ_A : REQ_B);
    gnt_a      = 1'b0;
    gnt_b      = 1'b0;
    if (req_a && req_b) begin
      gnt_a = (tie_winner == REQ_A);
      gnt_b = (tie_winner == REQ_B);
    end else begin
      gnt_a = req_a;
      gnt_b = req_b;
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with bounded burst lock sharing one synchronous data memory
// between the core (port A) and the loader (port B); read data is routed by tag.
module dmem_arbiter
  import brimstone_pkg::*;
#(
  parameter int unsigned BURST_MAX_P = BURST_MAX_DEF
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  localparam int unsigned CntW = $clog2(BURST_MAX_P + 1);

  req_id_t         last_r;
  logic            lock_active_r;
  req_id_t         lock_owner_r;
  logic [CntW-1:0] burst_cnt_r;
  rd_tag_t         rd_tag_r;

  logic            req_a_ok;
  logic            req_b_ok;
  logic            gnt_a;
  logic            gnt_b;
  logic            any_gnt;
  req_id_t         gnt_id;
  logic            gnt_wr;
  logic            gnt_lock;
  logic            owner_req;
  logic [CntW-1:0] burst_next;

  // Grants are suppressed combinationally while disabled or held in reset.
  assign req_a_ok = bus.i_a_req & bus.i_enable & ~reset;
  assign req_b_ok = bus.i_b_req & bus.i_enable & ~reset;

  rr_pick2 u_pick (
    .req_a       (req_a_ok),
    .req_b       (req_b_ok),
    .last        (last_r),
    .lock_active (lock_active_r),
    .lock_owner  (lock_owner_r),
    .gnt_a       (gnt_a),
    .gnt_b       (gnt_b)
  );

  always_comb begin
    any_gnt    = gnt_a | gnt_b;
    gnt_id     = gnt_b ? REQ_B : REQ_A;
    gnt_wr     = gnt_b ? bus.i_b_wr_en : bus.i_a_wr_en;
    gnt_lock   = gnt_b ? bus.i_b_lock : bus.i_a_lock;
    owner_req  = (lock_owner_r == REQ_B) ? bus.i_b_req : bus.i_a_req;
    burst_next = (lock_active_r && lock_owner_r == gnt_id) ? burst_cnt_r + CntW'(1) : CntW'(1);

    bus.o_a_gnt       = gnt_a;
    bus.o_b_gnt       = gnt_b;
    bus.o_mem_wr_en   = any_gnt & gnt_wr;
    bus.o_mem_addr    = '0;
    bus.o_mem_wr_data = '0;
    if (gnt_a) begin
      bus.o_mem_addr    = bus.i_a_addr;
      bus.o_mem_wr_data = bus.i_a_wr_data;
    end else if (gnt_b) begin
      bus.o_mem_addr    = bus.i_b_addr;
      bus.o_mem_wr_data = bus.i_b_wr_data;
    end

    bus.o_a_rd_valid = rd_tag_r.valid && (rd_tag_r.id == REQ_A);
    bus.o_b_rd_valid = rd_tag_r.valid && (rd_tag_r.id == REQ_B);
    bus.o_a_rd_data  = bus.o_a_rd_valid ? bus.i_mem_rd_data : '0;
    bus.o_b_rd_data  = bus.o_b_rd_valid ? bus.i_mem_rd_data : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_r        <= REQ_B;
      lock_active_r <= 1'b0;
      lock_owner_r  <= REQ_A;
      burst_cnt_r   <= '0;
      rd_tag_r      <= '{valid: 1'b0, id: REQ_A};
    end else begin
      rd_tag_r <= '{valid: any_gnt & ~gnt_wr, id: gnt_id};
      if (any_gnt) begin
        last_r <= gnt_id;
        if (gnt_lock && burst_next != CntW'(BURST_MAX_P)) begin
          lock_active_r <= 1'b1;
          lock_owner_r  <= gnt_id;
          burst_cnt_r   <= burst_next;
        end else begin
          // Unlocked grant or burst limit reached: last_r now favours the other port.
          lock_active_r <= 1'b0;
          burst_cnt_r   <= '0;
        end
      end else if (lock_active_r && !owner_req) begin
        lock_active_r <= 1'b0;
        burst_cnt_r   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small synchronous memory model.
module tb_dmem_arbiter;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  dmem_arbiter_if #(.DATA_WIDTH_P(32), .DATA_ADDR_WIDTH_P(32)) bus ();

  dmem_arbiter #(.BURST_MAX_P(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.o_mem_wr_en) mem[bus.o_mem_addr[7:0]] <= bus.o_mem_wr_data;
    bus.i_mem_rd_data <= mem[bus.o_mem_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_a_req = 0; bus.i_b_req = 0; bus.i_a_wr_en = 0; bus.i_b_wr_en = 0;
    bus.i_a_lock = 0; bus.i_b_lock = 0;
  endtask

  task automatic pulse_reset();
    reset = 1;
    #1;
    reset = 0;
    #1;
  endtask

  logic [6:0] lock_seq;

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h11] = 32'h11111111;
    bus.i_mem_rd_data = '0;
    bus.i_enable = 1; bus.i_a_addr = 0; bus.i_b_addr = 0;
    bus.i_a_wr_data = 0; bus.i_b_wr_data = 0;
    idle();
    reset = 1;
    tick();

    // Reset state with both requesting a write
    bus.i_a_req = 1; bus.i_b_req = 1; bus.i_a_wr_en = 1; bus.i_b_wr_en = 1;
    bus.i_a_addr = 32'h44; bus.i_a_wr_data = 32'h77;
    #1;
    chk("rst_a_gnt", {31'b0, bus.o_a_gnt}, 0);
    chk("rst_b_gnt", {31'b0, bus.o_b_gnt}, 0);
    chk("rst_wr_en", {31'b0, bus.o_mem_wr_en}, 0);
    chk("rst_addr", bus.o_mem_addr, 0);
    chk("rst_wdata", bus.o_mem_wr_data, 0);
    chk("rst_a_rdv", {31'b0, bus.o_a_rd_valid}, 0);
    chk("rst_b_rdv", {31'b0, bus.o_b_rd_valid}, 0);
    chk("rst_a_rdd", bus.o_a_rd_data, 0);
    idle();
    tick();
    reset = 0;
    #1;

    // A alone reads 0x10
    bus.i_a_req = 1; bus.i_a_addr = 32'h10;
    #1;
    chk("a_rd_gnt", {31'b0, bus.o_a_gnt}, 1);
    chk("a_rd_bgnt", {31'b0, bus.o_b_gnt}, 0);
    chk("a_rd_addr", bus.o_mem_addr, 32'h10);
    chk("a_rd_wren", {31'b0, bus.o_mem_wr_en}, 0);
    tick();
    idle();
    #1;
    chk("a_rd_valid", {31'b0, bus.o_a_rd_valid}, 1);
    chk("a_rd_data", bus.o_a_rd_data, 32'hDEADBEEF);
    chk("a_rd_bvalid", {31'b0, bus.o_b_rd_valid}, 0);
    chk("a_rd_bdata", bus.o_b_rd_data, 0);
    tick();
    chk("a_rd_once", {31'b0, bus.o_a_rd_valid}, 0);

    // Round robin after reset: A,B,A,B with routed read data
    pulse_reset();
    bus.i_a_req = 1; bus.i_b_req = 1; bus.i_a_addr = 32'h10; bus.i_b_addr = 32'h11;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_a_gnt%0d", i), {31'b0, bus.o_a_gnt}, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("rr_b_gnt%0d", i), {31'b0, bus.o_b_gnt}, (i % 2 == 1) ? 1 : 0);
      if (i > 0) begin
        chk($sformatf("rr_a_rdd%0d", i), bus.o_a_rd_data, (i % 2 == 1) ? 32'hDEADBEEF : 0);
        chk($sformatf("rr_b_rdd%0d", i), bus.o_b_rd_data, (i % 2 == 0) ? 32'h11111111 : 0);
      end
      tick();
    end
    idle();
    #1;
    chk("rr_b_last_rdv", {31'b0, bus.o_b_rd_valid}, 1);
    chk("rr_b_last_rdd", bus.o_b_rd_data, 32'h11111111);
    tick();

    // B locked burst: A (first tie), B x4, A, B
    pulse_reset();
    lock_seq = 7'b0100001;
    bus.i_a_req = 1; bus.i_b_req = 1; bus.i_b_lock = 1;
    #1;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("lock_a_gnt%0d", i), {31'b0, bus.o_a_gnt}, {31'b0, lock_seq[i]});
      chk($sformatf("lock_b_gnt%0d", i), {31'b0, bus.o_b_gnt}, {31'b0, ~lock_seq[i]});
      tick();
    end
    idle();
    tick();

    // B writes 0x5A5A5A5A to 0x20, A reads it back
    bus.i_b_req = 1; bus.i_b_wr_en = 1; bus.i_b_addr = 32'h20; bus.i_b_wr_data = 32'h5A5A5A5A;
    #1;
    chk("wr_b_gnt", {31'b0, bus.o_b_gnt}, 1);
    chk("wr_wren", {31'b0, bus.o_mem_wr_en}, 1);
    chk("wr_addr", bus.o_mem_addr, 32'h20);
    chk("wr_wdata", bus.o_mem_wr_data, 32'h5A5A5A5A);
    tick();
    idle();
    bus.i_a_req = 1; bus.i_a_addr = 32'h20;
    #1;
    chk("wr_rd_a_gnt", {31'b0, bus.o_a_gnt}, 1);
    chk("wr_rd_wren", {31'b0, bus.o_mem_wr_en}, 0);
    chk("wr_no_resp", {31'b0, bus.o_b_rd_valid}, 0);
    tick();
    idle();
    #1;
    chk("wr_rd_valid", {31'b0, bus.o_a_rd_valid}, 1);
    chk("wr_rd_data", bus.o_a_rd_data, 32'h5A5A5A5A);
    tick();

    // Enable low blocks grants; raising it grants A first
    pulse_reset();
    bus.i_enable = 0;
    bus.i_a_req = 1; bus.i_b_req = 1; bus.i_a_wr_en = 1; bus.i_b_wr_en = 1;
    bus.i_a_addr = 32'h30; bus.i_a_wr_data = 32'hCAFE0000;
    #1;
    chk("en0_a_gnt", {31'b0, bus.o_a_gnt}, 0);
    chk("en0_b_gnt", {31'b0, bus.o_b_gnt}, 0);
    chk("en0_wren", {31'b0, bus.o_mem_wr_en}, 0);
    tick();
    chk("en0_a_gnt2", {31'b0, bus.o_a_gnt}, 0);
    bus.i_enable = 1;
    #1;
    chk("en1_a_gnt", {31'b0, bus.o_a_gnt}, 1);
    chk("en1_b_gnt", {31'b0, bus.o_b_gnt}, 0);
    chk("en1_wren", {31'b0, bus.o_mem_wr_en}, 1);
    tick();
    idle();

    // Enable falls with a read outstanding: response still issues
    bus.i_a_req = 1; bus.i_a_addr = 32'h10;
    #1;
    chk("enf_a_gnt", {31'b0, bus.o_a_gnt}, 1);
    tick();
    idle();
    bus.i_enable = 0;
    #1;
    chk("enf_rdv", {31'b0, bus.o_a_rd_valid}, 1);
    chk("enf_rdd", bus.o_a_rd_data, 32'hDEADBEEF);
    tick();
    bus.i_enable = 1;

    // Reset after an A read grant discards the response
    pulse_reset();
    bus.i_b_req = 1; bus.i_b_addr = 32'h11;
    #1;
    tick();
    idle();
    bus.i_a_req = 1; bus.i_a_addr = 32'h10;
    #1;
    chk("rmid_a_gnt", {31'b0, bus.o_a_gnt}, 1);
    tick();
    idle();
    reset = 1;
    #1;
    chk("rmid_a_rdv", {31'b0, bus.o_a_rd_valid}, 0);
    chk("rmid_a_rdd", bus.o_a_rd_data, 0);
    chk("rmid_b_rdv", {31'b0, bus.o_b_rd_valid}, 0);
    chk("rmid_addr", bus.o_mem_addr, 0);
    tick();
    reset = 0;
    #1;
    chk("rmid_post_rdv", {31'b0, bus.o_a_rd_valid}, 0);
    bus.i_a_req = 1; bus.i_b_req = 1;
    #1;
    chk("rmid_tie_a", {31'b0, bus.o_a_gnt}, 1);
    chk("rmid_tie_b", {31'b0, bus.o_b_gnt}, 0);
    tick();
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
